// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB 1.1 receive control path.
package usb_rx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
  localparam int MAX_BYTES_DEF = 64;

  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;
  localparam int BYTE_CNT_W_DEF = $clog2(MAX_BYTES_DEF + 1);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    DATA_RCV,
    STORE,
    FULL,
    EOP_WAIT,
    ERR_WAIT,
    ERR_EOP,
    ERR_IDLE
  } rx_state_t;

  // Byte counter must be able to hold MAX_BYTES itself, not just MAX_BYTES-1.
  function automatic int byte_cnt_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/rx_bit_cnt.sv
// Bit-within-byte counter: wraps 7->0 on enable; wrap pulse is registered, so a
// byte event is seen the cycle after the 8th enable. No backpressure.
module rx_bit_cnt
  import usb_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [BIT_CNT_W-1:0] cnt_o,
  output logic                 wrap_o,
  output logic                 zero_o
);

  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d  = cnt_q + BIT_CNT_W'(1);
      wrap_d = (cnt_q == BIT_CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rx_ctrl.sv
// USB RX framing control: SYNC check, one FIFO write per data byte, sticky framing error.
// w_enable lands 2 cycles after the 8th shift of a byte; FIFO is never backpressured.
module rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  localparam int BYTE_CNT_W = byte_cnt_w(MAX_BYTES);
  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(MAX_BYTES - 1);

  rx_state_t               state_q, state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                    end_pend_q, end_pend_d;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    byte_evt, bit_zero, cnt_clr, valid_end, wrap_now;

  assign cnt_clr   = d_edge && (state_q == IDLE || state_q == ERR_IDLE);
  assign valid_end = eop && shift_enable;
  assign wrap_now  = shift_enable && (bit_cnt == BIT_CNT_MAX);

  rx_bit_cnt u_bit_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (cnt_clr),
    .en_i   (shift_enable),
    .cnt_o  (bit_cnt),
    .wrap_o (byte_evt),
    .zero_o (bit_zero)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      end_pend_q <= end_pend_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (cnt_clr) byte_cnt_d = '0;
    else if (state_q == STORE) byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
  end

  // An end that arrives with the byte's last bit (or with its byte event) is a
  // boundary end; remember it until the byte has been stored.
  always_comb begin
    end_pend_d = end_pend_q;
    if (!(state_q inside {DATA_RCV, STORE, FULL})) end_pend_d = 1'b0;
    else if (state_q == DATA_RCV && valid_end && (byte_evt || wrap_now)) end_pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (d_edge) state_d = SYNC_RCV;
      SYNC_RCV: begin
        if (byte_evt) state_d = SYNC_CHK;
        else if (valid_end) state_d = ERR_EOP;
      end
      SYNC_CHK: state_d = (rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_WAIT;
      DATA_RCV: begin
        if (byte_evt) state_d = STORE;
        else if (end_pend_q) state_d = EOP_WAIT;
        else if (valid_end && bit_zero) state_d = EOP_WAIT;
        else if (valid_end && !wrap_now) state_d = ERR_EOP;
      end
      STORE:    state_d = (byte_cnt_q == LAST_IDX) ? FULL : DATA_RCV;
      FULL: begin
        if (byte_evt) state_d = ERR_WAIT;
        else if (end_pend_q || (valid_end && bit_zero)) state_d = EOP_WAIT;
        else if (valid_end) state_d = ERR_EOP;
      end
      EOP_WAIT: if (d_edge) state_d = IDLE;
      ERR_WAIT: if (valid_end) state_d = ERR_EOP;
      ERR_EOP:  if (d_edge) state_d = ERR_IDLE;
      ERR_IDLE: if (d_edge) state_d = SYNC_RCV;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rcving   = 1'b1;
    w_enable = 1'b0;
    r_error  = 1'b0;
    case (state_q)
      IDLE:              rcving = 1'b0;
      STORE:             w_enable = 1'b1;
      ERR_WAIT, ERR_EOP: r_error = 1'b1;
      ERR_IDLE: begin
        rcving  = 1'b0;
        r_error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// Bench for rx_ctrl: random packets from a packet-level model; expected FIFO
// writes are queued at issue time and popped by an independent monitor.
module tb_rx_ctrl;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       rcving, w_enable, r_error;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;
  bit edges_ok = 1'b0;

  typedef struct {
    logic [7:0] dat;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected byte and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && w_enable === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got write of %0h, expected no write (cycle %0d)", rcv_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", rcv_data, e.dat);
        check("wr_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(3, 6);
    for (int i = 0; i < g; i++) begin
      d_edge = edges_ok && ($urandom_range(0, 3) == 0);
      tick();
      d_edge = 1'b0;
    end
  endtask

  // One sampled bit, LSB-first into the shift register; psh queues the byte that
  // should be written two cycles after this shift.
  task automatic shift_bit(input logic b, input logic e, input bit psh, input logic [7:0] dat);
    shift_enable = 1'b1;
    eop = e;
    if (psh) exp_q.push_back('{dat: dat, at: cyc + 2});
    tick();
    shift_enable = 1'b0;
    rcv_data = {b, rcv_data[7:1]};
    gap();
  endtask

  task automatic send_pkt(input logic [7:0] sync, input int n, input int extra,
                          input bit coinc, input bit rst_mid);
    bit         sync_ok, exp_err, last_eop;
    int         exp_wr, wr0;
    logic [7:0] b;
    sync_ok = (sync == 8'h80);
    exp_wr  = !sync_ok ? 0 : ((n < MAXB) ? n : MAXB);
    exp_err = !sync_ok || (n > MAXB) || (extra != 0);
    wr0     = wr_seen;

    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    check("start_rcving", rcving, 1);
    check("start_rerr", r_error, 0);

    edges_ok = 1'b1;
    for (int i = 0; i < 8; i++) shift_bit(sync[i], 1'b0, 1'b0, 8'h00);
    check("sync_rerr", r_error, !sync_ok);

    for (int j = 0; j < n; j++) begin
      b = 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) begin
        if (rst_mid && j == 3 && i == 3) begin
          n_rst = 1'b0;
          #1;
          check("rst_rcving", rcving, 0);
          check("rst_wen", w_enable, 0);
          check("rst_rerr", r_error, 0);
          tick();
          n_rst = 1'b1;
          edges_ok = 1'b0;
          rcv_data = 8'h00;
          tick();
          check("rst_wr_count", wr_seen - wr0, 3);
          check("rst_q_empty", exp_q.size(), 0);
          return;
        end
        last_eop = coinc && (j == n - 1) && (i == 7);
        if (last_eop) edges_ok = 1'b0;
        shift_bit(b[i], last_eop, sync_ok && (j < MAXB) && (i == 7), b);
      end
    end

    for (int i = 0; i < extra; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00);
    edges_ok = 1'b0;
    if (!coinc) shift_bit(1'b0, 1'b1, 1'b0, 8'h00);
    shift_bit(1'b0, 1'b1, 1'b0, 8'h00);
    eop = 1'b0;
    tick();
    check("end_rcving", rcving, 1);
    check("end_rerr", r_error, exp_err);

    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    check("idle_rcving", rcving, 0);
    check("idle_rerr", r_error, exp_err);
    check("wr_count", wr_seen - wr0, exp_wr);
    check("q_empty", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic idle_noise();
    eop = 1'b1;
    repeat (3) begin
      shift_enable = 1'b1;
      tick();
      shift_enable = 1'b0;
      tick();
    end
    eop = 1'b0;
    tick();
    check("noise_rcving", rcving, 0);
    check("noise_rerr", r_error, 0);
  endtask

  initial begin
    logic [7:0] sync;
    int         n, extra;
    bit         coinc;

    tick();
    check("reset_rcving", rcving, 0);
    check("reset_wen", w_enable, 0);
    check("reset_rerr", r_error, 0);
    n_rst = 1'b1;
    repeat (2) tick();

    send_pkt(8'h80, 2, 0, 1'b0, 1'b0);
    send_pkt(8'h81, 2, 0, 1'b0, 1'b0);
    send_pkt(8'h80, 1, 3, 1'b0, 1'b0);
    send_pkt(8'h80, 5, 0, 1'b0, 1'b0);
    send_pkt(8'h80, 2, 0, 1'b1, 1'b0);
    send_pkt(8'h80, 4, 0, 1'b0, 1'b0);
    send_pkt(8'h80, 4, 0, 1'b1, 1'b0);
    send_pkt(8'h80, 0, 0, 1'b0, 1'b0);
    send_pkt(8'h80, 5, 0, 1'b0, 1'b1);
    send_pkt(8'h80, 3, 0, 1'b0, 1'b0);
    idle_noise();

    for (int r = 0; r < 24; r++) begin
      sync  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
      n     = $urandom_range(0, 6);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      coinc = (n > 0) && (extra == 0) && ($urandom_range(0, 1) == 1);
      send_pkt(sync, n, extra, coinc, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
- Receiver control unit for the USB 1.1 RX path. Sits directly downstream of the EOP detector, edge detector and shift register, in parallel with them.
- Tracks packet framing: detects packet start from the first line edge, validates the SYNC byte, and issues one write strobe per received data byte to the RX FIFO.
- Accepts end of packet only on a byte boundary. Flags framing errors and holds them until the next packet begins.

Parameters:
- SYNC_BYTE, 8'h80: value rcv_data must hold after the first 8 shifted bits.
- MAX_BYTES, 64: maximum data bytes per packet (after SYNC). One more byte is an error.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- d_edge  input  1  one-cycle pulse on a decoded line transition
- eop  input  1  registered EOP (SE0 held) indication from the EOP detector; level, may stay high several cycles
- shift_enable  input  1  one-cycle pulse per sampled bit; shift register advances on it
- rcv_data  input  8  current shift register contents
- rcving  output  1  high while a packet is in progress
- w_enable  output  1  one-cycle FIFO write strobe; byte = rcv_data in that cycle
- r_error  output  1  packet framing error, sticky until next packet start

Behaviour:
- Reset: asynchronous and active-low. State IDLE; bit_cnt=0, byte_cnt=0; rcving=0, w_enable=0, r_error=0.
- Outputs are Moore, decoded from registered state only. No input-to-output combinational path.
- Byte event: internal 3-bit bit_cnt increments on shift_enable and wraps 7->0. A wrap is a byte event, occurring the cycle after the 8th shift_enable.
- Valid end: eop && shift_enable.
- States:
  - IDLE: d_edge -> SYNC_RCV; clear bit_cnt and byte_cnt.
  - SYNC_RCV (rcving=1): byte event -> SYNC_CHK. Valid end -> ERR_EOP.
  - SYNC_CHK (rcving=1, one cycle): rcv_data==SYNC_BYTE -> DATA_RCV, else -> ERR_WAIT.
  - DATA_RCV (rcving=1):
    - byte event -> STORE.
    - valid end with bit_cnt==0 -> EOP_WAIT.
    - valid end with bit_cnt!=0 -> ERR_EOP.
  - STORE (rcving=1, w_enable=1, one cycle): byte_cnt++.
    - byte_cnt was MAX_BYTES-1 -> FULL, else -> DATA_RCV.
  - FULL (rcving=1): any further byte event -> ERR_WAIT. Valid end with bit_cnt==0 -> EOP_WAIT.
  - EOP_WAIT (rcving=1): d_edge (SE0->J) -> IDLE.
  - ERR_WAIT (rcving=1, r_error=1): valid end -> ERR_EOP. bit_cnt keeps counting; no w_enable issued.
  - ERR_EOP (rcving=1, r_error=1): d_edge -> ERR_IDLE.
  - ERR_IDLE (rcving=0, r_error=1): d_edge -> SYNC_RCV; r_error drops that same transition; counters cleared.
- Simultaneous events:
  - Byte event and valid end in the same cycle in DATA_RCV: byte event wins. The byte is stored, then the end is evaluated in DATA_RCV with bit_cnt==0.
  - d_edge in SYNC_CHK or STORE is ignored.
- Latency: w_enable asserts exactly 2 cycles after the 8th shift_enable of a data byte.
- eop high while not in a receive state is ignored.
- Reset mid-packet: immediate return to IDLE. r_error cleared. No w_enable emitted.

Decomposition:
- Shared package usb_rx_pkg:
  - rx_state_t enum of the 10 states above.
  - SYNC_BYTE default constant.
  - Bit-count and byte-count width localparams, byte count width = $clog2(MAX_BYTES+1).
- Sub-module rx_bit_cnt: 3-bit wrap counter with clear and enable. Outputs wrap pulse and zero flag.
- FSM plus byte counter stay in rx_ctrl.

Test Plan:
- SYNC 8'h80, 2 data bytes, EOP on boundary -> rcving 1 from cycle after d_edge; exactly 2 w_enable pulses; rcving 0 after final d_edge; r_error stays 0.
- SYNC byte 8'h81 -> r_error=1 from the cycle after SYNC_CHK. No w_enable for the following bytes. r_error held through EOP and ERR_IDLE; cleared on next d_edge.
- Valid end after 1 data byte plus 3 extra bits -> one w_enable, then r_error=1, rcving stays 1 until the next d_edge.
- MAX_BYTES=4, send 5 data bytes -> 4 w_enable pulses, 5th byte sets r_error.
- 8th shift_enable coincident with eop -> byte stored (w_enable), clean EOP_WAIT, no error.
- n_rst asserted mid-byte after 3 data bytes -> all outputs 0 immediately. Next packet with valid SYNC is received normally.
